// File: rtl/div_pkg.sv
// ---------------------------------------------------------------------------
// div_pkg
// Shared definitions for the sequential restoring divider.
//   DIV_WIDTH    : default divisor / quotient / remainder width
//   div_state_t  : FSM state encoding (IDLE, RUN, DONE)
// ---------------------------------------------------------------------------
package div_pkg;

    localparam int DIV_WIDTH = 16;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } div_state_t;

endpackage : div_pkg

// File: rtl/div_step.sv
// ---------------------------------------------------------------------------
// div_step
// One iteration of the restoring division. It shifts the next dividend bit
// into the partial remainder and subtracts the divisor when the result is
// non-negative.
//   i_rem     : partial remainder before the shift (always < divisor)
//   i_bit     : next dividend bit, shifted in at the LSB
//   i_divisor : divisor
//   o_rem     : partial remainder after this step (again < divisor)
//   o_q_bit   : quotient bit produced by this step
// ---------------------------------------------------------------------------
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic             i_bit,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_rem,
    output logic             o_q_bit
);

    logic [WIDTH:0] w_shifted;
    logic [WIDTH:0] w_diff;

    // The shifted remainder is at most 2*divisor-1, so WIDTH+1 bits hold it.
    // A negative difference always has its top bit set, so that bit is the
    // sign of t.
    assign w_shifted = {i_rem, i_bit};
    assign w_diff    = w_shifted - {1'b0, i_divisor};
    assign o_q_bit   = ~w_diff[WIDTH];

    // Both candidates are below the divisor here, so WIDTH bits are enough.
    assign o_rem = o_q_bit ? w_diff[WIDTH-1:0] : w_shifted[WIDTH-1:0];

endmodule : div_step

// File: rtl/seq_divider_16bit.sv
// ---------------------------------------------------------------------------
// seq_divider_16bit
// Iterative restoring divider: a 2*WIDTH-bit dividend divided by a WIDTH-bit
// divisor gives a WIDTH-bit quotient and remainder after WIDTH RUN cycles.
// Divide-by-zero and quotient overflow are detected when the operation is
// accepted, and these cases finish in one cycle.
//
// Ports
//   clk         : rising-edge clock
//   rst         : synchronous active-high reset
//   start       : operation request, accepted in IDLE or DONE (ignored in RUN)
//   A           : dividend, captured on the accepted start
//   B           : divisor, captured on the accepted start
//   busy        : high while iterating
//   done        : one-cycle pulse; Q/R/flags are valid from this cycle on
//   Q, R        : quotient and remainder of the last finished operation
//   div_by_zero : last operation had B == 0
//   overflow    : last operation's quotient did not fit in WIDTH bits
//   dbg_state   : current FSM state (div_state_t encoding)
//
// Handshake: a start is taken on any rising edge where start=1 and the FSM is
// not in RUN. done rises one edge after the FSM passes through DONE. The
// outputs then hold until the done of the next accepted operation.
// ---------------------------------------------------------------------------
module seq_divider_16bit
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [2*WIDTH-1:0] A,
    input  logic [WIDTH-1:0]   B,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   Q,
    output logic [WIDTH-1:0]   R,
    output logic               div_by_zero,
    output logic               overflow,
    output logic [1:0]         dbg_state
);

    localparam int             CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);

    div_state_t       r_state;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_rem;    // partial remainder; stays below r_b
    logic [WIDTH-1:0] r_qsr;    // dividend low half, shifted into quotient
    logic [CW-1:0]    r_cnt;
    logic             r_dbz;    // flags of the operation in flight
    logic             r_ovf;

    logic             w_accept;
    logic [WIDTH-1:0] w_rem_next;
    logic             w_q_bit;
    logic [WIDTH-1:0] w_a_hi;
    logic [WIDTH-1:0] w_a_lo;

    assign w_accept  = start && (r_state != S_RUN);
    assign w_a_hi    = A[2*WIDTH-1:WIDTH];
    assign w_a_lo    = A[WIDTH-1:0];
    assign dbg_state = r_state;

    div_step #(.WIDTH(WIDTH)) u_step (
        .i_rem     (r_rem),
        .i_bit     (r_qsr[WIDTH-1]),
        .i_divisor (r_b),
        .o_rem     (w_rem_next),
        .o_q_bit   (w_q_bit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            Q           <= '0;
            R           <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            r_b         <= '0;
            r_rem       <= '0;
            r_qsr       <= '0;
            r_cnt       <= '0;
            r_dbz       <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            done <= 1'b0;

            case (r_state)
                S_RUN: begin
                    r_rem <= w_rem_next;
                    r_qsr <= {r_qsr[WIDTH-2:0], w_q_bit};
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == LAST_CNT) begin
                        r_state <= S_DONE;
                        busy    <= 1'b0;
                    end
                end
                S_DONE: begin
                    // Publish the results. A start accepted in this same
                    // cycle is loaded below and does not disturb them.
                    done        <= 1'b1;
                    Q           <= r_qsr;
                    R           <= r_rem;
                    div_by_zero <= r_dbz;
                    overflow    <= r_ovf;
                    r_state     <= S_IDLE;
                end
                default: begin
                end
            endcase

            // An accepted start overrides the state update above. The
            // published flags stay as they are until the new operation
            // reaches DONE; only the in-flight copies are cleared here.
            if (w_accept) begin
                r_b   <= B;
                r_cnt <= '0;
                r_dbz <= 1'b0;
                r_ovf <= 1'b0;
                if (B == '0) begin
                    r_dbz   <= 1'b1;
                    r_qsr   <= '1;
                    r_rem   <= w_a_lo;
                    r_state <= S_DONE;
                    busy    <= 1'b0;
                end else if (w_a_hi >= B) begin
                    r_ovf   <= 1'b1;
                    r_qsr   <= '1;
                    r_rem   <= '0;
                    r_state <= S_DONE;
                    busy    <= 1'b0;
                end else begin
                    r_rem   <= w_a_hi;
                    r_qsr   <= w_a_lo;
                    r_state <= S_RUN;
                    busy    <= 1'b1;
                end
            end
        end
    end

endmodule : seq_divider_16bit

// File: doc/seq_divider_16bit.md
Name: seq_divider_16bit

Overview:
- Iterative restoring divider; the inverse datapath of the 16-bit multiplier in the MAC block.
- Takes a 32-bit dividend (a product-width value) and a 16-bit divisor.
- Returns a 16-bit quotient and a 16-bit remainder after WIDTH iteration cycles.
- Sits beside the multiplier so the MAC can normalise or scale accumulated products.

Parameters:
- WIDTH, 16: divisor, quotient and remainder width. The dividend is 2*WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only when the block is not busy
- A  input  2*WIDTH  dividend; captured on the accepted start
- B  input  WIDTH  divisor; captured on the accepted start
- busy  output  1  high while iterating
- done  output  1  one-cycle pulse; results valid from this cycle
- Q  output  WIDTH  quotient
- R  output  WIDTH  remainder
- div_by_zero  output  1  error flag for the last operation
- overflow  output  1  quotient of the last operation does not fit in WIDTH bits

Behaviour:
- Reset: one clock is used; rst is synchronous and active-high.
  - State goes to IDLE.
  - busy, done, Q, R, div_by_zero and overflow all go to 0.
  - Reset mid-operation aborts the operation; no done pulse is produced.
- States: IDLE, RUN, DONE.
- Start acceptance: start is accepted in IDLE or DONE, so back-to-back operations work. start during RUN is ignored.
- On an accepted start:
  - Latch B.
  - rem (WIDTH+1 bits) <= A[2W-1:W].
  - qsr <= A[W-1:0].
  - cnt <= 0.
  - Clear div_by_zero and overflow.
- Early exits at acceptance:
  - B == 0: go to DONE next cycle. div_by_zero=1, Q=all ones, R=A[W-1:0].
  - Otherwise, A[2W-1:W] >= B: go to DONE next cycle. overflow=1, Q=all ones, R=0.
  - If both hold, div_by_zero takes priority.
  - Otherwise go to RUN with busy=1.
- RUN, each cycle:
  - Shift {rem,qsr} left by 1.
  - t = shifted_rem - B, computed at WIDTH+1 bits.
  - If t is non-negative: rem=t and qsr[0]=1. Otherwise keep the shifted rem and set qsr[0]=0.
  - cnt increments.
  - After WIDTH cycles (cnt==WIDTH-1), go to DONE.
- DONE:
  - done=1 for exactly one cycle and busy=0.
  - Q=qsr and R=rem[W-1:0], registered.
  - Go to IDLE unless a new start is accepted in this cycle.
- Latency: start accepted at edge 0 gives done high after edge WIDTH+1. Error cases give done high after edge 1.
- Output hold: Q, R and the flags hold their values until the next accepted start's done. They are not cleared in IDLE.
- Invariant: rem < B before each shift, so WIDTH+1 bits suffice and the final R < B.

Decomposition:
- Shared package div_pkg:
  - WIDTH default.
  - State encoding constants for IDLE, RUN and DONE.
- One combinational sub-module, div_step:
  - Inputs: rem_in and the next dividend bit.
  - Compares against B and outputs rem_out and q_bit.
  - Instantiated once inside the RUN datapath.

Test Plan:
- Exact division: A=0xFE010000, B=0xFF00 -> done after 17 cycles; Q=0xFF00, R=0x0000, flags 0.
- With remainder: A=0x4B95CBEF, B=0x7511 -> Q=0xA54A, R=0x0005, overflow=0.
- Error cases:
  - A=0x12345678, B=0 -> done after 1 cycle; div_by_zero=1, Q=0xFFFF, R=0x5678.
  - A=0x00010000, B=0x0001 -> done after 1 cycle; overflow=1, Q=0xFFFF, R=0.
- Start ignored and reset abort:
  - start pulsed mid-RUN with A=0, B=1 -> ignored; first result is unaffected.
  - rst at cycle 5 of RUN -> no done pulse; all outputs 0; the next operation runs correctly.
- Back-to-back and random:
  - New start in the DONE cycle (A=100, B=7) -> accepted; next done gives Q=14, R=2.
  - 1000 random cases with A[31:16] < B -> A == Q*B+R and R < B.
